// File: rtl/reset_sequencer_mc_if.sv
// rtl/reset_sequencer_mc_if.sv - control/status bundle for reset_sequencer_mc
// LOCK_LOSS_COUNT exists only when RESET_SEQ_EVENT_CNT_EN is defined.
interface reset_sequencer_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int LOCK_WIDTH = 2
);
  logic                  EXT_RESET_N;
  logic [LOCK_WIDTH-1:0] LOCK;
  logic [NUM_CH-1:0]     SOFT_RESET;
  logic                  CLR_FLAGS;
  logic [NUM_CH-1:0]     RESET_N_OUT;
  logic                  INIT_DONE;
  logic [1:0]            SEQ_STATE;
  logic                  LOCK_LOST;
  logic                  LOCK_FAULT;
`ifdef RESET_SEQ_EVENT_CNT_EN
  logic [7:0]            LOCK_LOSS_COUNT;
`endif

  modport master (
    output EXT_RESET_N, LOCK, SOFT_RESET, CLR_FLAGS,
    input  RESET_N_OUT, INIT_DONE, SEQ_STATE, LOCK_LOST, LOCK_FAULT
`ifdef RESET_SEQ_EVENT_CNT_EN
    , input LOCK_LOSS_COUNT
`endif
  );

  modport slave (
    input  EXT_RESET_N, LOCK, SOFT_RESET, CLR_FLAGS,
    output RESET_N_OUT, INIT_DONE, SEQ_STATE, LOCK_LOST, LOCK_FAULT
`ifdef RESET_SEQ_EVENT_CNT_EN
    , output LOCK_LOSS_COUNT
`endif
  );
endinterface

// File: rtl/reset_sequencer_mc.sv
// rtl/reset_sequencer_mc.sv - multi-channel reset sequencer with lock supervision
// Defining RESET_SEQ_EVENT_CNT_EN adds the saturating LOCK_LOSS_COUNT output.
module reset_sequencer_mc #(
  parameter int NUM_CH       = 4,
  parameter int LOCK_WIDTH   = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_ASSERT   = 16,
  parameter int STEP_DELAY   = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK_BASE,
  input  logic                 FAB_RESET,
  reset_sequencer_mc_if.slave  bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'((MIN_ASSERT >= 2) ? MIN_ASSERT - 2 : 0);
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT      = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] er_sync;
  logic [LOCK_WIDTH-1:0]  lock_sync [SYNC_STAGES];
  logic                   er;
  logic                   lk;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_CH-1:0]      rst_out;
  logic                   init_done;
  logic                   lock_lost;
  logic                   lock_fault;
  logic [CNT_W-1:0]       soft_cnt [NUM_CH];
`ifdef RESET_SEQ_EVENT_CNT_EN
  logic [7:0]             loss_cnt;
`endif

  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      er_sync <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) lock_sync[s] <= '0;
    end else begin
      er_sync      <= {er_sync[SYNC_STAGES-2:0], bus.EXT_RESET_N};
      lock_sync[0] <= bus.LOCK;
      for (int s = 1; s < SYNC_STAGES; s++) lock_sync[s] <= lock_sync[s-1];
    end
  end

  assign er = er_sync[SYNC_STAGES-1];
  assign lk = &lock_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_out    <= '0;
      init_done  <= 1'b0;
      lock_lost  <= 1'b0;
      lock_fault <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) soft_cnt[i] <= '0;
`ifdef RESET_SEQ_EVENT_CNT_EN
      loss_cnt   <= 8'd0;
`endif
    end else begin
      // Clears land first so that a coincident set event further down wins.
      if (bus.CLR_FLAGS) begin
        lock_lost  <= 1'b0;
        lock_fault <= 1'b0;
`ifdef RESET_SEQ_EVENT_CNT_EN
        loss_cnt   <= 8'd0;
`endif
      end

      if (!er || (!lk && (state == ST_RELEASE || state == ST_DONE))) begin
        state     <= ST_ASSERT;
        cnt       <= '0;
        idx       <= '0;
        rst_out   <= '0;
        init_done <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) soft_cnt[i] <= '0;
        if (er) begin
          lock_lost <= 1'b1;
`ifdef RESET_SEQ_EVENT_CNT_EN
          if (bus.CLR_FLAGS)        loss_cnt <= 8'd1;
          else if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
`endif
        end
      end else begin
        case (state)
          ST_ASSERT: begin
            rst_out <= '0;
            if (cnt >= ASSERT_LAST) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_WAIT_LOCK: begin
            if (lk) begin
              // The exit edge already counts as the first cycle of release spacing.
              state <= ST_RELEASE;
              cnt   <= CNT_W'(1);
              idx   <= '0;
            end else if (cnt < TIMEOUT) begin
              cnt <= cnt + CNT_W'(1);
              if (cnt == TIMEOUT_LAST) lock_fault <= 1'b1;
            end
          end

          ST_RELEASE: begin
            if (cnt >= STEP_LAST) begin
              rst_out[idx] <= 1'b1;
              cnt          <= '0;
              if (idx == IDX_LAST) begin
                state     <= ST_DONE;
                init_done <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_DONE: begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (bus.SOFT_RESET[i]) begin
                rst_out[i]  <= 1'b0;
                soft_cnt[i] <= '0;
              end else if (!rst_out[i]) begin
                if (soft_cnt[i] >= STEP_LAST) begin
                  rst_out[i]  <= 1'b1;
                  soft_cnt[i] <= '0;
                end else begin
                  soft_cnt[i] <= soft_cnt[i] + CNT_W'(1);
                end
              end
            end
          end

          default: state <= ST_ASSERT;
        endcase
      end
    end
  end

  assign bus.RESET_N_OUT = rst_out;
  assign bus.INIT_DONE   = init_done;
  assign bus.SEQ_STATE   = state;
  assign bus.LOCK_LOST   = lock_lost;
  assign bus.LOCK_FAULT  = lock_fault;
`ifdef RESET_SEQ_EVENT_CNT_EN
  assign bus.LOCK_LOSS_COUNT = loss_cnt;
`endif

endmodule

// File: tb/tb_reset_sequencer_mc.sv
// tb/tb_reset_sequencer_mc.sv - directed bench for reset_sequencer_mc
module tb_reset_sequencer_mc;

  logic clk = 1'b0;
  logic fab_reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  reset_sequencer_mc_if #(.NUM_CH(4), .LOCK_WIDTH(2)) bus ();

  reset_sequencer_mc #(
    .NUM_CH(4), .LOCK_WIDTH(2), .SYNC_STAGES(2), .MIN_ASSERT(16),
    .STEP_DELAY(8), .LOCK_TIMEOUT(4096), .CNT_W(16)
  ) dut (
    .CLK_BASE (clk),
    .FAB_RESET(fab_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic do_reset(input logic [1:0] lock_val);
    fab_reset       = 1'b1;
    bus.EXT_RESET_N = 1'b1;
    bus.LOCK        = lock_val;
    bus.SOFT_RESET  = 4'b0000;
    bus.CLR_FLAGS   = 1'b0;
    tick(3);
    fab_reset = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    fab_reset       = 1'b1;
    bus.EXT_RESET_N = 1'b1;
    bus.LOCK        = 2'b11;
    bus.SOFT_RESET  = 4'b1111;
    bus.CLR_FLAGS   = 1'b0;
    tick(3);
    checks++; if (bus.RESET_N_OUT !== 4'b0000) begin errors++; $display("FAIL reset_rst_out: got %b expected 0000", bus.RESET_N_OUT); end
    checks++; if (bus.INIT_DONE !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", bus.INIT_DONE); end
    checks++; if (bus.SEQ_STATE !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.SEQ_STATE); end
    checks++; if (bus.LOCK_LOST !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b expected 0", bus.LOCK_LOST); end
    checks++; if (bus.LOCK_FAULT !== 1'b0) begin errors++; $display("FAIL reset_lock_fault: got %b expected 0", bus.LOCK_FAULT); end
  endtask

  task automatic test_nominal();
    int         t_cyc  [10] = '{15, 16, 17, 23, 24, 31, 32, 40, 47, 48};
    logic [3:0] t_rst  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h7, 4'h7, 4'hF};
    logic       t_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [1:0] t_st   [10] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    do_reset(2'b11);
    for (int k = 0; k < 10; k++) begin
      go_to(t_cyc[k]);
      checks++; if (bus.RESET_N_OUT !== t_rst[k]) begin errors++; $display("FAIL nominal_rst_out@%0d: got %b expected %b", cyc, bus.RESET_N_OUT, t_rst[k]); end
      checks++; if (bus.INIT_DONE !== t_done[k]) begin errors++; $display("FAIL nominal_init_done@%0d: got %b expected %b", cyc, bus.INIT_DONE, t_done[k]); end
      checks++; if (bus.SEQ_STATE !== t_st[k]) begin errors++; $display("FAIL nominal_state@%0d: got %0d expected %0d", cyc, bus.SEQ_STATE, t_st[k]); end
    end
    checks++; if (bus.LOCK_LOST !== 1'b0 || bus.LOCK_FAULT !== 1'b0) begin errors++; $display("FAIL nominal_flags: got %b%b expected 00", bus.LOCK_LOST, bus.LOCK_FAULT); end
  endtask

  task automatic test_soft_reset();
    go_to(60);
    bus.SOFT_RESET = 4'b0100;
    go_to(61);
    checks++; if (bus.RESET_N_OUT !== 4'b1011) begin errors++; $display("FAIL soft_assert: got %b expected 1011", bus.RESET_N_OUT); end
    checks++; if (bus.INIT_DONE !== 1'b1) begin errors++; $display("FAIL soft_init_done: got %b expected 1", bus.INIT_DONE); end
    go_to(65);
    bus.SOFT_RESET = 4'b0000;
    go_to(72);
    checks++; if (bus.RESET_N_OUT !== 4'b1011) begin errors++; $display("FAIL soft_hold72: got %b expected 1011", bus.RESET_N_OUT); end
    go_to(73);
    checks++; if (bus.RESET_N_OUT !== 4'b1111) begin errors++; $display("FAIL soft_release73: got %b expected 1111", bus.RESET_N_OUT); end
    checks++; if (bus.SEQ_STATE !== 2'd3) begin errors++; $display("FAIL soft_state: got %0d expected 3", bus.SEQ_STATE); end
  endtask

  task automatic test_lock_loss();
    go_to(100);
    bus.LOCK = 2'b01;
    go_to(102);
    checks++; if (bus.RESET_N_OUT !== 4'b1111) begin errors++; $display("FAIL loss_sync_delay: got %b expected 1111", bus.RESET_N_OUT); end
    bus.CLR_FLAGS = 1'b1;
    go_to(103);
    bus.CLR_FLAGS = 1'b0;
    checks++; if (bus.RESET_N_OUT !== 4'b0000) begin errors++; $display("FAIL loss_rst_out: got %b expected 0000", bus.RESET_N_OUT); end
    checks++; if (bus.INIT_DONE !== 1'b0) begin errors++; $display("FAIL loss_init_done: got %b expected 0", bus.INIT_DONE); end
    checks++; if (bus.LOCK_LOST !== 1'b1) begin errors++; $display("FAIL loss_set_beats_clr: got %b expected 1", bus.LOCK_LOST); end
    checks++; if (bus.SEQ_STATE !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d expected 0", bus.SEQ_STATE); end
`ifdef RESET_SEQ_EVENT_CNT_EN
    checks++; if (bus.LOCK_LOSS_COUNT !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d expected 1", bus.LOCK_LOSS_COUNT); end
`endif
    go_to(110);
    bus.LOCK = 2'b11;
    go_to(118);
    checks++; if (bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL loss_rewait: got %0d expected 1", bus.SEQ_STATE); end
    go_to(149);
    checks++; if (bus.INIT_DONE !== 1'b0) begin errors++; $display("FAIL loss_done_early: got %b expected 0", bus.INIT_DONE); end
    go_to(150);
    checks++; if (bus.INIT_DONE !== 1'b1 || bus.RESET_N_OUT !== 4'b1111) begin errors++; $display("FAIL loss_redone: got %b/%b expected 1/1111", bus.INIT_DONE, bus.RESET_N_OUT); end
    checks++; if (bus.LOCK_LOST !== 1'b1) begin errors++; $display("FAIL loss_sticky: got %b expected 1", bus.LOCK_LOST); end
    bus.CLR_FLAGS = 1'b1;
    go_to(151);
    bus.CLR_FLAGS = 1'b0;
    checks++; if (bus.LOCK_LOST !== 1'b0) begin errors++; $display("FAIL loss_clear: got %b expected 0", bus.LOCK_LOST); end
  endtask

  task automatic test_ext_reset();
    go_to(160);
    bus.EXT_RESET_N = 1'b0;
    go_to(162);
    checks++; if (bus.RESET_N_OUT !== 4'b1111) begin errors++; $display("FAIL ext_sync_delay: got %b expected 1111", bus.RESET_N_OUT); end
    go_to(163);
    bus.EXT_RESET_N = 1'b1;
    checks++; if (bus.RESET_N_OUT !== 4'b0000 || bus.INIT_DONE !== 1'b0) begin errors++; $display("FAIL ext_reassert: got %b/%b expected 0000/0", bus.RESET_N_OUT, bus.INIT_DONE); end
    checks++; if (bus.LOCK_LOST !== 1'b0) begin errors++; $display("FAIL ext_no_lock_lost: got %b expected 0", bus.LOCK_LOST); end
    go_to(179);
    checks++; if (bus.SEQ_STATE !== 2'd0) begin errors++; $display("FAIL ext_assert_hold: got %0d expected 0", bus.SEQ_STATE); end
    go_to(180);
    checks++; if (bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL ext_wait_lock: got %0d expected 1", bus.SEQ_STATE); end
    go_to(211);
    checks++; if (bus.INIT_DONE !== 1'b0) begin errors++; $display("FAIL ext_done_early: got %b expected 0", bus.INIT_DONE); end
    go_to(212);
    checks++; if (bus.INIT_DONE !== 1'b1 || bus.RESET_N_OUT !== 4'b1111) begin errors++; $display("FAIL ext_redone: got %b/%b expected 1/1111", bus.INIT_DONE, bus.RESET_N_OUT); end
    checks++; if (bus.LOCK_LOST !== 1'b0) begin errors++; $display("FAIL ext_lock_lost_final: got %b expected 0", bus.LOCK_LOST); end
  endtask

  task automatic test_fab_reset_mid();
    do_reset(2'b11);
    go_to(25);
    bus.SOFT_RESET = 4'b0001;
    go_to(27);
    checks++; if (bus.RESET_N_OUT !== 4'b0001) begin errors++; $display("FAIL soft_ignored_in_release: got %b expected 0001", bus.RESET_N_OUT); end
    bus.SOFT_RESET = 4'b0000;
    go_to(30);
    fab_reset = 1'b1;
    go_to(31);
    fab_reset = 1'b0;
    checks++; if (bus.RESET_N_OUT !== 4'b0000 || bus.SEQ_STATE !== 2'd0) begin errors++; $display("FAIL fab_mid_reset: got %b/%0d expected 0000/0", bus.RESET_N_OUT, bus.SEQ_STATE); end
    cyc = -1;
    go_to(16);
    checks++; if (bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL fab_restart_wait: got %0d expected 1", bus.SEQ_STATE); end
    go_to(24);
    checks++; if (bus.RESET_N_OUT !== 4'b0001) begin errors++; $display("FAIL fab_restart_first: got %b expected 0001", bus.RESET_N_OUT); end
    go_to(48);
    checks++; if (bus.RESET_N_OUT !== 4'b1111 || bus.INIT_DONE !== 1'b1) begin errors++; $display("FAIL fab_restart_done: got %b/%b expected 1111/1", bus.RESET_N_OUT, bus.INIT_DONE); end
  endtask

  task automatic test_lock_timeout();
    do_reset(2'b00);
    go_to(16);
    checks++; if (bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL timeout_wait_entry: got %0d expected 1", bus.SEQ_STATE); end
    go_to(4111);
    checks++; if (bus.LOCK_FAULT !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", bus.LOCK_FAULT); end
    go_to(4112);
    checks++; if (bus.LOCK_FAULT !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b expected 1", bus.LOCK_FAULT); end
    checks++; if (bus.RESET_N_OUT !== 4'b0000 || bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL timeout_hold: got %b/%0d expected 0000/1", bus.RESET_N_OUT, bus.SEQ_STATE); end
    go_to(4120);
    checks++; if (bus.LOCK_FAULT !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", bus.LOCK_FAULT); end
    bus.CLR_FLAGS = 1'b1;
    go_to(4121);
    bus.CLR_FLAGS = 1'b0;
    go_to(4123);
    checks++; if (bus.LOCK_FAULT !== 1'b0 || bus.SEQ_STATE !== 2'd1) begin errors++; $display("FAIL timeout_clear: got %b/%0d expected 0/1", bus.LOCK_FAULT, bus.SEQ_STATE); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_soft_reset();
    test_lock_loss();
    test_ext_reset();
    test_fab_reset_mid();
    test_lock_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
